bp_cfg_responder: RTL and testbench
===================================

# bp_cfg_responder

Configuration-bus responder for one BlackParrot core tile. It accepts read and write commands from the host config link and holds the tile's runtime configuration registers: freeze, boot PC, core ID, device ID, and cache and CCE modes. It also exposes a read-only window that reports the static processor configuration selected by `bp_params_p`, so software can discover the build's dimensions. It sits between the I/O-side config link and the core/CCE control inputs.

## Interface
Parameters:
- `bp_params_p`, default `e_bp_single_core_cfg`: selects the entry of `all_cfgs_gp` that supplies the read-only window and all field widths.
- `cfg_addr_width_p`, default 16: command address width.
- `cfg_data_width_p`, default 64: command and response data width.
- `core_id_width_p`, default 8: width of the `core_id` register.
- `boot_pc_p`, default 39'h00_8000_0000: reset value of `npc`.

Ports:
- `clk_i`  in  1  clock; all state on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `cmd_v_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command ready.
- `cmd_w_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  `cfg_addr_width_p`  register address.
- `cmd_data_i`  in  `cfg_data_width_p`  write data.
- `resp_v_o`  out  1  response valid.
- `resp_yumi_i`  in  1  response consumed; legal only while `resp_v_o`=1.
- `resp_data_o`  out  `cfg_data_width_p`  read data; 0 for writes.
- `resp_err_o`  out  1  unmapped address, or write to a read-only address.
- `freeze_o`  out  1  holds the core frozen.
- `npc_o`  out  `vaddr_width`  boot PC.
- `core_id_o`  out  `core_id_width_p`  core ID.
- `did_o`  out  `io_noc_did_width`  device ID.
- `icache_mode_o`, `dcache_mode_o`, `cce_mode_o`  out  1 each  0 = uncached, 1 = normal.

## Operation
- **Handshake.** A command is accepted when `cmd_v_i & cmd_ready_o`.
  - `cmd_ready_o = ~resp_v_o | resp_yumi_i`.
  - Every accepted command produces exactly one response.
- **Read/write registers:**
  - 0x0000 `freeze`, reset 1.
  - 0x0001 `npc`, reset `boot_pc_p`.
  - 0x0002 `core_id`, reset 0.
  - 0x0003 `did`, reset 0.
  - 0x0004 `icache_mode`, reset 0.
  - 0x0005 `dcache_mode`, reset 0.
  - 0x0006 `cce_mode`, reset 0.
- **Read-only window**, fields taken from the selected config:
  - 0x0100 `cc_x_dim`, 0x0101 `cc_y_dim`
  - 0x0102 `vaddr_width`, 0x0103 `paddr_width`
  - 0x0104 `lce_sets`, 0x0105 `lce_assoc`
  - 0x0106 `lce_dcache_sets`, 0x0107 `lce_dcache_assoc`
  - 0x0108 `cce_block_width`, 0x0109 `io_noc_did_width`
  - 0x010A `bp_params_p` enum value
- **Width rules.** Writes keep the low field-width bits of `cmd_data_i`. Reads zero-extend the field to `cfg_data_width_p`.
- **Errors.** Reads of unmapped addresses return data 0 with `resp_err_o`=1. Writes to unmapped or read-only addresses change no state and respond with `resp_err_o`=1.
- **Response buffer.** A single entry holding data and err. It is overwritten only in a cycle where it is empty or being consumed by `resp_yumi_i`.

## Timing
- **Reset values.** `resp_v_o`=0, `resp_data_o`=0, `resp_err_o`=0, `cmd_ready_o`=1 in the cycle after reset. Configuration outputs take the reset values listed under Operation.
- **Write latency.** A write accepted in cycle N updates its register and output at the edge ending cycle N, so the new value is visible in N+1. The response is `resp_v_o`=1 in N+1.
- **Read latency.** A read accepted in cycle N gives `resp_v_o`=1 in N+1, carrying the register value as of cycle N.
- **Back-to-back.** A write in N followed by a read of the same address in N+1 returns the written value.
- **Full buffer.** With `resp_v_o`=1 and `resp_yumi_i`=0, `cmd_ready_o`=0 and all state holds.
- **Consume and accept together.** `resp_yumi_i` and a new accept in the same cycle give throughput of one command per cycle, with `resp_v_o` staying 1.
- **Reset mid-operation.** Asserting `reset_i` drops any pending response; `resp_v_o`=0 on the next cycle and every register returns to its reset value.
- **Output timing.** All configuration outputs are driven directly from registers, with no combinational path from `cmd_*`.

## Structure
- **Shared package `bp_common_cfg_link_pkg`:**
  - `bp_cfg_addr_e` enum holding every address above.
  - `bp_cfg_cmd_s` struct {w, addr, data}.
  - `bp_cfg_resp_s` struct {err, data}.
  - Cache/CCE mode enum: `e_mode_uncached`=0, `e_mode_normal`=1.
- **Config source.** Read-only values come from `all_cfgs_gp[bp_params_p]`; they are not duplicated in this block.
- **Sub-module.** The response buffer is one `bsg_one_fifo` carrying `bp_cfg_resp_s`. The register file and address decode stay in this module.

## Test plan
1. **Reset state.** Release reset → `freeze_o`=1, `npc_o`=0x0080000000, all modes 0, `resp_v_o`=0, `cmd_ready_o`=1.
2. **Write then read, back-to-back.** Write `npc` = 0x1_2345_6789 with `resp_yumi_i` held 1, then read 0x0001 → write response err=0 data=0; read response data 0x1_2345_6789; `npc_o` updates one cycle after accept.
3. **Config discovery, single-core build.** Read 0x0100, 0x0102, 0x0107 → 1, 39, 4; write 0x0100 → err=1 and state unchanged.
4. **Backpressure.** Hold `resp_yumi_i`=0, issue a read and then a write to `freeze` = 0 → `cmd_ready_o`=0 after the first accept and `freeze_o` stays 1; raising yumi accepts the write the same cycle, and `freeze_o`=0 one cycle later.
5. **Unmapped and wide writes.** Write 0xFFFF_FFFF_FFFF_FFFF to `core_id` → reads back 0xFF. Read 0x0042 → data 0, err=1.
6. **Reset mid-operation.** Assert `reset_i` while a response is pending and `freeze`=0 → next cycle `resp_v_o`=0, `freeze_o`=1.

Source files
------------

// File: rtl/bp_cfg_responder_pkg.sv
// Shared config-link types: address map, command/response structs, cache/CCE
// modes and the table of static processor configurations.
package bp_common_cfg_link_pkg;

  localparam int unsigned cfg_addr_width_gp = 16;
  localparam int unsigned cfg_data_width_gp = 64;

  typedef enum logic [1:0] {
    e_bp_single_core_cfg = 2'd0,
    e_bp_dual_core_cfg   = 2'd1,
    e_bp_quad_core_cfg   = 2'd2,
    e_bp_oct_core_cfg    = 2'd3
  } bp_params_e;

  typedef struct packed {
    int unsigned cc_x_dim;
    int unsigned cc_y_dim;
    int unsigned vaddr_width;
    int unsigned paddr_width;
    int unsigned lce_sets;
    int unsigned lce_assoc;
    int unsigned lce_dcache_sets;
    int unsigned lce_dcache_assoc;
    int unsigned cce_block_width;
    int unsigned io_noc_did_width;
  } bp_proc_param_s;

  localparam bp_proc_param_s all_cfgs_gp [4] = '{
    '{cc_x_dim: 1, cc_y_dim: 1, vaddr_width: 39, paddr_width: 40, lce_sets: 64, lce_assoc: 8,
      lce_dcache_sets: 64, lce_dcache_assoc: 4, cce_block_width: 512, io_noc_did_width: 3},
    '{cc_x_dim: 2, cc_y_dim: 1, vaddr_width: 39, paddr_width: 40, lce_sets: 64, lce_assoc: 8,
      lce_dcache_sets: 64, lce_dcache_assoc: 4, cce_block_width: 512, io_noc_did_width: 3},
    '{cc_x_dim: 2, cc_y_dim: 2, vaddr_width: 39, paddr_width: 40, lce_sets: 64, lce_assoc: 8,
      lce_dcache_sets: 64, lce_dcache_assoc: 4, cce_block_width: 512, io_noc_did_width: 3},
    '{cc_x_dim: 4, cc_y_dim: 2, vaddr_width: 39, paddr_width: 40, lce_sets: 64, lce_assoc: 8,
      lce_dcache_sets: 64, lce_dcache_assoc: 4, cce_block_width: 512, io_noc_did_width: 3}
  };

  typedef enum logic [cfg_addr_width_gp-1:0] {
    e_cfg_freeze           = 16'h0000,
    e_cfg_npc              = 16'h0001,
    e_cfg_core_id          = 16'h0002,
    e_cfg_did              = 16'h0003,
    e_cfg_icache_mode      = 16'h0004,
    e_cfg_dcache_mode      = 16'h0005,
    e_cfg_cce_mode         = 16'h0006,
    e_cfg_cc_x_dim         = 16'h0100,
    e_cfg_cc_y_dim         = 16'h0101,
    e_cfg_vaddr_width      = 16'h0102,
    e_cfg_paddr_width      = 16'h0103,
    e_cfg_lce_sets         = 16'h0104,
    e_cfg_lce_assoc        = 16'h0105,
    e_cfg_lce_dcache_sets  = 16'h0106,
    e_cfg_lce_dcache_assoc = 16'h0107,
    e_cfg_cce_block_width  = 16'h0108,
    e_cfg_io_noc_did_width = 16'h0109,
    e_cfg_params           = 16'h010A
  } bp_cfg_addr_e;

  typedef enum logic {
    e_mode_uncached = 1'b0,
    e_mode_normal   = 1'b1
  } bp_mode_e;

  typedef struct packed {
    logic                         w;
    logic [cfg_addr_width_gp-1:0] addr;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_cmd_s;

  typedef struct packed {
    logic                         err;
    logic [cfg_data_width_gp-1:0] data;
  } bp_cfg_resp_s;

endpackage

// File: rtl/bp_cfg_responder_one_fifo.sv
// Single-entry valid/ready buffer; may be refilled in the same cycle it is consumed.
module bsg_one_fifo #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic               r_full;
  logic [width_p-1:0] r_data;

  assign ready_o = ~r_full | yumi_i;
  assign v_o     = r_full;
  assign data_o  = r_data;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (v_i & ready_o) begin
      r_full <= 1'b1;
      r_data <= data_i;
    end else if (yumi_i) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/bp_cfg_responder.sv
// Config-bus responder for one core tile: runtime config registers plus a
// read-only window describing the static build configuration.
module bp_cfg_responder
  import bp_common_cfg_link_pkg::*;
#(
  parameter bp_params_e  bp_params_p      = e_bp_single_core_cfg,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 64,
  parameter int unsigned core_id_width_p  = 8,
  localparam bp_proc_param_s cfg_lp       = all_cfgs_gp[bp_params_p],
  localparam int unsigned vaddr_width_lp  = cfg_lp.vaddr_width,
  localparam int unsigned did_width_lp    = cfg_lp.io_noc_did_width,
  parameter logic [vaddr_width_lp-1:0] boot_pc_p = 39'h00_8000_0000
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        cmd_v_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_w_i,
  input  logic [cfg_addr_width_p-1:0] cmd_addr_i,
  input  logic [cfg_data_width_p-1:0] cmd_data_i,
  output logic                        resp_v_o,
  input  logic                        resp_yumi_i,
  output logic [cfg_data_width_p-1:0] resp_data_o,
  output logic                        resp_err_o,
  output logic                        freeze_o,
  output logic [vaddr_width_lp-1:0]   npc_o,
  output logic [core_id_width_p-1:0]  core_id_o,
  output logic [did_width_lp-1:0]     did_o,
  output logic                        icache_mode_o,
  output logic                        dcache_mode_o,
  output logic                        cce_mode_o
);

  logic                       r_freeze;
  logic [vaddr_width_lp-1:0]  r_npc;
  logic [core_id_width_p-1:0] r_core_id;
  logic [did_width_lp-1:0]    r_did;
  bp_mode_e                   r_icache_mode;
  bp_mode_e                   r_dcache_mode;
  bp_mode_e                   r_cce_mode;

  bp_cfg_cmd_s                  w_cmd;
  bp_cfg_resp_s                 w_resp;
  bp_cfg_resp_s                 w_resp_q;
  logic                         w_fifo_ready;
  logic                         w_accept;
  logic                         w_addr_hi_zero;
  logic                         w_mapped;
  logic                         w_ro;
  logic                         w_wr_en;
  logic [cfg_data_width_gp-1:0] w_rdata;

  assign w_cmd.w        = cmd_w_i;
  assign w_cmd.addr     = cfg_addr_width_gp'(cmd_addr_i);
  assign w_cmd.data     = cfg_data_width_gp'(cmd_data_i);
  // Wide address buses must not alias onto the 16-bit map.
  assign w_addr_hi_zero = ((64'(cmd_addr_i) >> cfg_addr_width_gp) == '0);

  always_comb begin
    w_rdata  = '0;
    w_ro     = 1'b0;
    w_mapped = 1'b1;
    case (w_cmd.addr)
      e_cfg_freeze:           w_rdata = 64'(r_freeze);
      e_cfg_npc:              w_rdata = 64'(r_npc);
      e_cfg_core_id:          w_rdata = 64'(r_core_id);
      e_cfg_did:              w_rdata = 64'(r_did);
      e_cfg_icache_mode:      w_rdata = 64'(r_icache_mode);
      e_cfg_dcache_mode:      w_rdata = 64'(r_dcache_mode);
      e_cfg_cce_mode:         w_rdata = 64'(r_cce_mode);
      e_cfg_cc_x_dim:         begin w_rdata = 64'(cfg_lp.cc_x_dim);         w_ro = 1'b1; end
      e_cfg_cc_y_dim:         begin w_rdata = 64'(cfg_lp.cc_y_dim);         w_ro = 1'b1; end
      e_cfg_vaddr_width:      begin w_rdata = 64'(cfg_lp.vaddr_width);      w_ro = 1'b1; end
      e_cfg_paddr_width:      begin w_rdata = 64'(cfg_lp.paddr_width);      w_ro = 1'b1; end
      e_cfg_lce_sets:         begin w_rdata = 64'(cfg_lp.lce_sets);         w_ro = 1'b1; end
      e_cfg_lce_assoc:        begin w_rdata = 64'(cfg_lp.lce_assoc);        w_ro = 1'b1; end
      e_cfg_lce_dcache_sets:  begin w_rdata = 64'(cfg_lp.lce_dcache_sets);  w_ro = 1'b1; end
      e_cfg_lce_dcache_assoc: begin w_rdata = 64'(cfg_lp.lce_dcache_assoc); w_ro = 1'b1; end
      e_cfg_cce_block_width:  begin w_rdata = 64'(cfg_lp.cce_block_width);  w_ro = 1'b1; end
      e_cfg_io_noc_did_width: begin w_rdata = 64'(cfg_lp.io_noc_did_width); w_ro = 1'b1; end
      e_cfg_params:           begin w_rdata = 64'(bp_params_p);             w_ro = 1'b1; end
      default:                w_mapped = 1'b0;
    endcase
    if (!w_addr_hi_zero) begin
      w_rdata  = '0;
      w_ro     = 1'b0;
      w_mapped = 1'b0;
    end
  end

  assign w_accept    = cmd_v_i & w_fifo_ready;
  assign w_wr_en     = w_accept & w_cmd.w & w_mapped & ~w_ro;
  assign w_resp.err  = ~w_mapped | (w_cmd.w & w_ro);
  assign w_resp.data = w_cmd.w ? '0 : w_rdata;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_freeze      <= 1'b1;
      r_npc         <= boot_pc_p;
      r_core_id     <= '0;
      r_did         <= '0;
      r_icache_mode <= e_mode_uncached;
      r_dcache_mode <= e_mode_uncached;
      r_cce_mode    <= e_mode_uncached;
    end else if (w_wr_en) begin
      case (w_cmd.addr)
        e_cfg_freeze:      r_freeze      <= w_cmd.data[0];
        e_cfg_npc:         r_npc         <= w_cmd.data[vaddr_width_lp-1:0];
        e_cfg_core_id:     r_core_id     <= w_cmd.data[core_id_width_p-1:0];
        e_cfg_did:         r_did         <= w_cmd.data[did_width_lp-1:0];
        e_cfg_icache_mode: r_icache_mode <= bp_mode_e'(w_cmd.data[0]);
        e_cfg_dcache_mode: r_dcache_mode <= bp_mode_e'(w_cmd.data[0]);
        e_cfg_cce_mode:    r_cce_mode    <= bp_mode_e'(w_cmd.data[0]);
        default: ;
      endcase
    end
  end

  bsg_one_fifo #(
    .width_p($bits(bp_cfg_resp_s))
  ) u_resp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ready_o (w_fifo_ready),
    .v_i     (w_accept),
    .data_i  (w_resp),
    .v_o     (resp_v_o),
    .data_o  (w_resp_q),
    .yumi_i  (resp_yumi_i)
  );

  assign cmd_ready_o   = w_fifo_ready;
  assign resp_data_o   = cfg_data_width_p'(w_resp_q.data);
  assign resp_err_o    = w_resp_q.err;
  assign freeze_o      = r_freeze;
  assign npc_o         = r_npc;
  assign core_id_o     = r_core_id;
  assign did_o         = r_did;
  assign icache_mode_o = r_icache_mode;
  assign dcache_mode_o = r_dcache_mode;
  assign cce_mode_o    = r_cce_mode;

endmodule

// File: tb/tb_bp_cfg_responder.sv
// Scoreboard bench for bp_cfg_responder: a reference register model queues the
// expected response for every accepted command; a monitor checks each consumed one.
module tb_bp_cfg_responder;

  logic        clk;
  logic        reset_i;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic        cmd_w_i;
  logic [15:0] cmd_addr_i;
  logic [63:0] cmd_data_i;
  logic        resp_v_o;
  logic        resp_yumi_i;
  logic [63:0] resp_data_o;
  logic        resp_err_o;
  logic        freeze_o;
  logic [38:0] npc_o;
  logic [7:0]  core_id_o;
  logic [2:0]  did_o;
  logic        icache_mode_o;
  logic        dcache_mode_o;
  logic        cce_mode_o;

  logic yumi_en;
  assign resp_yumi_i = yumi_en & resp_v_o;

  bp_cfg_responder dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_w_i       (cmd_w_i),
    .cmd_addr_i    (cmd_addr_i),
    .cmd_data_i    (cmd_data_i),
    .resp_v_o      (resp_v_o),
    .resp_yumi_i   (resp_yumi_i),
    .resp_data_o   (resp_data_o),
    .resp_err_o    (resp_err_o),
    .freeze_o      (freeze_o),
    .npc_o         (npc_o),
    .core_id_o     (core_id_o),
    .did_o         (did_o),
    .icache_mode_o (icache_mode_o),
    .dcache_mode_o (dcache_mode_o),
    .cce_mode_o    (cce_mode_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Single-core build: x, y, vaddr, paddr, lce sets/assoc, dcache sets/assoc, block, did, enum
  localparam logic [63:0] RO_EXP [11] = '{64'd1, 64'd1, 64'd39, 64'd40, 64'd64, 64'd8,
                                          64'd64, 64'd4, 64'd512, 64'd3, 64'd0};

  logic        m_freeze;
  logic [63:0] m_npc;
  logic [63:0] m_core_id;
  logic [63:0] m_did;
  logic        m_ic, m_dc, m_cce;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_freeze  = 1'b1;
    m_npc     = 64'h00_8000_0000;
    m_core_id = '0;
    m_did     = '0;
    m_ic      = 1'b0;
    m_dc      = 1'b0;
    m_cce     = 1'b0;
  endtask

  task automatic model_cmd(input logic w, input logic [15:0] addr, input logic [63:0] data,
                           output exp_t e);
    int idx;
    e.err  = 1'b0;
    e.data = '0;
    case (addr)
      16'h0000: if (w) m_freeze  = data[0];                   else e.data = {63'd0, m_freeze};
      16'h0001: if (w) m_npc     = data & 64'h7F_FFFF_FFFF;   else e.data = m_npc;
      16'h0002: if (w) m_core_id = data & 64'hFF;             else e.data = m_core_id;
      16'h0003: if (w) m_did     = data & 64'h7;              else e.data = m_did;
      16'h0004: if (w) m_ic      = data[0];                   else e.data = {63'd0, m_ic};
      16'h0005: if (w) m_dc      = data[0];                   else e.data = {63'd0, m_dc};
      16'h0006: if (w) m_cce     = data[0];                   else e.data = {63'd0, m_cce};
      default: begin
        if (addr >= 16'h0100 && addr <= 16'h010A) begin
          idx = int'(addr) - 'h100;
          if (w) e.err = 1'b1; else e.data = RO_EXP[idx];
        end else begin
          e.err = 1'b1;
        end
      end
    endcase
  endtask

  // Drive one command from posedge+1; returns at posedge+1 after it is accepted.
  task automatic send(input logic w, input logic [15:0] addr, input logic [63:0] data);
    int   n;
    exp_t e;
    n          = 0;
    cmd_v_i    = 1'b1;
    cmd_w_i    = w;
    cmd_addr_i = addr;
    cmd_data_i = data;
    forever begin
      @(negedge clk);
      if (cmd_ready_o) break;
      n++;
      if (n >= 50) begin
        check_eq("cmd_accept_timeout", {63'd0, cmd_ready_o}, 64'd1);
        cmd_v_i = 1'b0;
        return;
      end
    end
    model_cmd(w, addr, data, e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_v_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    check_eq("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_v_o && resp_yumi_i) begin
      check_eq("sb_nonempty", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("resp_data", resp_data_o, e.data);
        check_eq("resp_err", {63'd0, resp_err_o}, {63'd0, e.err});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i    = 1'b1;
    cmd_v_i    = 1'b0;
    cmd_w_i    = 1'b0;
    cmd_addr_i = '0;
    cmd_data_i = '0;
    yumi_en    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_freeze",  {63'd0, freeze_o}, 64'd1);
    check_eq("rst_npc",     64'(npc_o), 64'h00_8000_0000);
    check_eq("rst_core_id", 64'(core_id_o), 64'd0);
    check_eq("rst_did",     64'(did_o), 64'd0);
    check_eq("rst_modes",   {61'd0, icache_mode_o, dcache_mode_o, cce_mode_o}, 64'd0);
    check_eq("rst_resp_v",  {63'd0, resp_v_o}, 64'd0);
    check_eq("rst_resp",    {resp_err_o, resp_data_o[62:0]}, 64'd0);
    check_eq("rst_ready",   {63'd0, cmd_ready_o}, 64'd1);
    @(posedge clk);
    #1;

    // Write then read back-to-back, response consumed every cycle
    yumi_en = 1'b1;
    check_eq("npc_before_wr", 64'(npc_o), 64'h00_8000_0000);
    send(1'b1, 16'h0001, 64'h1_2345_6789);
    check_eq("npc_after_wr", 64'(npc_o), 64'h1_2345_6789);
    send(1'b0, 16'h0001, 64'h0);
    check_eq("thru_resp_v", {63'd0, resp_v_o}, 64'd1);
    drain();

    // Read-only window, then a rejected write to it
    for (int i = 0; i < 11; i++) send(1'b0, 16'(16'h0100 + i), 64'h0);
    send(1'b1, 16'h0100, 64'h5);
    send(1'b0, 16'h0100, 64'h0);
    send(1'b0, 16'h0000, 64'h0);
    drain();

    // Backpressure: second command waits until the pending response is taken
    @(posedge clk);
    #1 yumi_en = 1'b0;
    send(1'b0, 16'h0000, 64'h0);
    fork
      send(1'b1, 16'h0000, 64'h0);
      begin
        repeat (3) begin
          @(negedge clk);
          check_eq("bp_ready", {63'd0, cmd_ready_o}, 64'd0);
          check_eq("bp_freeze_hold", {63'd0, freeze_o}, 64'd1);
        end
        @(posedge clk);
        #1 yumi_en = 1'b1;
      end
    join
    check_eq("bp_freeze_new", {63'd0, freeze_o}, 64'd0);
    drain();

    // Field truncation, unmapped addresses, mode bits
    send(1'b1, 16'h0002, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("core_id_o", 64'(core_id_o), 64'hFF);
    send(1'b0, 16'h0002, 64'h0);
    send(1'b0, 16'h0042, 64'h0);
    send(1'b1, 16'h0042, 64'h7);
    send(1'b1, 16'h0003, 64'hF);
    send(1'b0, 16'h0003, 64'h0);
    send(1'b1, 16'h0004, 64'h3);
    send(1'b1, 16'h0006, 64'h1);
    check_eq("modes_o", {61'd0, icache_mode_o, dcache_mode_o, cce_mode_o}, 64'b101);
    send(1'b0, 16'h0004, 64'h0);
    send(1'b0, 16'h0005, 64'h0);
    send(1'b0, 16'h0007, 64'h0);
    drain();

    // Reset while a response is pending
    @(posedge clk);
    #1 yumi_en = 1'b0;
    send(1'b1, 16'h0001, 64'h55);
    check_eq("pre_rst_resp_v", {63'd0, resp_v_o}, 64'd1);
    check_eq("pre_rst_freeze", {63'd0, freeze_o}, 64'd0);
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    check_eq("mid_rst_resp_v", {63'd0, resp_v_o}, 64'd0);
    check_eq("mid_rst_freeze", {63'd0, freeze_o}, 64'd1);
    check_eq("mid_rst_npc",    64'(npc_o), 64'h00_8000_0000);
    check_eq("mid_rst_modes",  {61'd0, icache_mode_o, dcache_mode_o, cce_mode_o}, 64'd0);
    @(posedge clk);
    #1 yumi_en = 1'b1;
    send(1'b0, 16'h0000, 64'h0);
    send(1'b0, 16'h0006, 64'h0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
